// File: rtl/serial_frame_rx_if.sv
// Serial frame receiver bus: sample strobe and line in, decoded word and
// status pulses out. The receiver connects through the slave modport.
interface serial_frame_rx_if #(
   parameter int DATA_W = 8
);
   logic              en;
   logic              data;
   logic [DATA_W-1:0] frame_data;
   logic              frame_valid;
   logic              frame_err;
   logic [1:0]        err_code;
   logic              busy;

   modport master (
      output en,
      output data,
      input  frame_data,
      input  frame_valid,
      input  frame_err,
      input  err_code,
      input  busy
   );

   modport slave (
      input  en,
      input  data,
      output frame_data,
      output frame_valid,
      output frame_err,
      output err_code,
      output busy
   );
endinterface

// File: rtl/serial_frame_rx.sv
// FSM serial frame receiver: start, DATA_W bits LSB first, stop.
// Define FRAME_PARITY_EN to add an odd-parity bit before the stop bit.
module serial_frame_rx #(
   parameter int DATA_W      = 8,
   parameter int TIMEOUT_CYC = 4096,
   parameter int CNT_W       = 13
) (
   input logic              clk,
   input logic              reset,
   serial_frame_rx_if.slave bus
);
   localparam int BW = $clog2(DATA_W + 1);
   localparam logic [BW-1:0] LAST = BW'(DATA_W - 1);
   localparam logic [CNT_W-1:0] TLIM = CNT_W'(TIMEOUT_CYC - 1);

`ifdef FRAME_PARITY_EN
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
`endif

   state_t            state;
   logic [BW-1:0]     bcnt;
   logic [CNT_W-1:0]  tcnt;
   logic [DATA_W-1:0] sh;
   logic [DATA_W-1:0] fdata;
   logic              fvalid;
   logic              ferr;
   logic [1:0]        ecode;
   logic              busy_q;
   logic              par_ok;

`ifdef FRAME_PARITY_EN
   logic par;
   assign par_ok = ^{sh, par};
`else
   assign par_ok = 1'b1;
`endif

   assign bus.frame_data  = fdata;
   assign bus.frame_valid = fvalid;
   assign bus.frame_err   = ferr;
   assign bus.err_code    = ecode;
   assign bus.busy        = busy_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         bcnt   <= '0;
         tcnt   <= '0;
         sh     <= '0;
         fdata  <= '0;
         fvalid <= 1'b0;
         ferr   <= 1'b0;
         ecode  <= 2'b00;
         busy_q <= 1'b0;
`ifdef FRAME_PARITY_EN
         par    <= 1'b0;
`endif
      end else begin
         fvalid <= 1'b0;
         ferr   <= 1'b0;
         if (!bus.en) begin
            // a stalled frame is dropped once the strobe stays away too long
            if (state != IDLE) begin
               if (tcnt == TLIM) begin
                  ferr   <= 1'b1;
                  ecode  <= 2'b11;
                  state  <= IDLE;
                  busy_q <= 1'b0;
                  tcnt   <= '0;
               end else begin
                  tcnt <= tcnt + CNT_W'(1);
               end
            end
         end else begin
            tcnt <= '0;
            unique case (state)
               IDLE: begin
                  if (!bus.data) begin
                     state  <= DATA;
                     busy_q <= 1'b1;
                     bcnt   <= '0;
                  end
               end
               DATA: begin
                  sh   <= {bus.data, sh[DATA_W-1:1]};
                  bcnt <= bcnt + BW'(1);
                  if (bcnt == LAST) begin
`ifdef FRAME_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end
               end
`ifdef FRAME_PARITY_EN
               PARITY: begin
                  par   <= bus.data;
                  state <= STOP;
               end
`endif
               STOP: begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
                  // stop-bit error outranks parity error
                  if (!bus.data) begin
                     ferr  <= 1'b1;
                     ecode <= 2'b01;
                  end else if (!par_ok) begin
                     ferr  <= 1'b1;
                     ecode <= 2'b10;
                  end else begin
                     fdata  <= sh;
                     fvalid <= 1'b1;
                  end
               end
               default: begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: expected pulses are queued when a frame is
// driven and matched, with cycle timing, when the receiver pulses.
module tb_serial_frame_rx;
   localparam int DW = 8;

   typedef struct {
      logic          err;
      logic [1:0]    code;
      logic [DW-1:0] data;
      int            cyc;
   } ev_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   int            cyc = 0;
   int            ncomp = 0;
   int            nfail = 0;
   logic [DW-1:0] last_good = '0;
   ev_t           exp_q[$];

   serial_frame_rx_if #(.DATA_W(DW)) bus();

   serial_frame_rx #(
      .DATA_W(DW),
      .TIMEOUT_CYC(16),
      .CNT_W(5)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin : mon
      ev_t e;
      if (bus.frame_valid === 1'b1 || bus.frame_err === 1'b1) begin
         ncomp++;
         if (bus.frame_valid && bus.frame_err) begin
            nfail++;
            $display("FAIL both_pulses cyc %0d got v=1 e=1 want one",
                     cyc);
         end else if (exp_q.size() == 0) begin
            nfail++;
            $display("FAIL unexpected_pulse cyc %0d got err=%b data=%h",
                     cyc, bus.frame_err, bus.frame_data);
         end else begin
            e = exp_q.pop_front();
            if (bus.frame_err !== e.err || bus.frame_data !== e.data ||
                cyc != e.cyc || (e.err && bus.err_code !== e.code)) begin
               nfail++;
               $display({"FAIL pulse got err=%b code=%b data=%h cyc=%0d",
                         " want err=%b code=%b data=%h cyc=%0d"},
                        bus.frame_err, bus.err_code, bus.frame_data, cyc,
                        e.err, e.code, e.data, e.cyc);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic sample(input logic b);
      bus.en = 1'b1;
      bus.data = b;
      tick();
      bus.en = 1'b0;
      bus.data = 1'b1;
   endtask

   task automatic push(input logic err, input logic [1:0] code,
                       input logic [DW-1:0] d, input int c);
      ev_t e;
      e.err = err;
      e.code = code;
      e.data = d;
      e.cyc = c;
      exp_q.push_back(e);
   endtask

   task automatic send_frame(input logic [DW-1:0] d, input logic p,
                             input logic stp, input int gap,
                             input int stall_at, input int stall_len);
      logic pok;
`ifdef FRAME_PARITY_EN
      pok = ^{d, p};
`else
      pok = 1'b1;
`endif
      sample(1'b0);
      idle(gap - 1);
      for (int i = 0; i < DW; i++) begin
         sample(d[i]);
         idle(gap - 1);
         if (i == stall_at) idle(stall_len);
      end
`ifdef FRAME_PARITY_EN
      sample(p);
      idle(gap - 1);
`endif
      if (!stp) begin
         push(1'b1, 2'b01, last_good, cyc + 1);
      end else if (!pok) begin
         push(1'b1, 2'b10, last_good, cyc + 1);
      end else begin
         push(1'b0, 2'b00, d, cyc + 1);
         last_good = d;
      end
      sample(stp);
      idle(gap - 1);
   endtask

   task automatic test_reset();
      bus.en = 1'b0;
      bus.data = 1'b1;
      reset = 1'b1;
      idle(3);
      reset = 1'b0;
      ncomp++;
      if (bus.frame_data !== '0) begin
         nfail++;
         $display("FAIL rst_data got %h want 00", bus.frame_data);
      end
      ncomp++;
      if (bus.frame_valid !== 1'b0) begin
         nfail++;
         $display("FAIL rst_valid got %b want 0", bus.frame_valid);
      end
      ncomp++;
      if (bus.frame_err !== 1'b0) begin
         nfail++;
         $display("FAIL rst_err got %b want 0", bus.frame_err);
      end
      ncomp++;
      if (bus.err_code !== 2'b00) begin
         nfail++;
         $display("FAIL rst_code got %b want 00", bus.err_code);
      end
      ncomp++;
      if (bus.busy !== 1'b0) begin
         nfail++;
         $display("FAIL rst_busy got %b want 0", bus.busy);
      end
   endtask

   task automatic test_good();
      send_frame(8'h5A, 1'b1, 1'b1, 4, -1, 0);
      idle(2);
      ncomp++;
      if (exp_q.size() != 0) begin
         nfail++;
         $display("FAIL good_missing got %0d left want 0", exp_q.size());
         exp_q.delete();
      end
      ncomp++;
      if (bus.busy !== 1'b0) begin
         nfail++;
         $display("FAIL good_busy got %b want 0", bus.busy);
      end
      ncomp++;
      if (bus.frame_data !== 8'h5A) begin
         nfail++;
         $display("FAIL good_data got %h want 5a", bus.frame_data);
      end
   endtask

`ifdef FRAME_PARITY_EN
   task automatic test_parity();
      send_frame(8'h5A, 1'b0, 1'b1, 4, -1, 0);
      idle(2);
      ncomp++;
      if (exp_q.size() != 0) begin
         nfail++;
         $display("FAIL par_missing got %0d left want 0", exp_q.size());
         exp_q.delete();
      end
      ncomp++;
      if (bus.frame_data !== 8'h5A) begin
         nfail++;
         $display("FAIL par_hold got %h want 5a", bus.frame_data);
      end
   endtask
`endif

   task automatic test_stop();
      logic [DW-1:0] d;
      d = 8'h3C;
      send_frame(d, ~^d, 1'b0, 4, -1, 0);
      idle(2);
      send_frame(d, ^d, 1'b0, 4, -1, 0);
      idle(2);
      ncomp++;
      if (exp_q.size() != 0) begin
         nfail++;
         $display("FAIL stop_missing got %0d left want 0", exp_q.size());
         exp_q.delete();
      end
      ncomp++;
      if (bus.err_code !== 2'b01) begin
         nfail++;
         $display("FAIL stop_code got %b want 01", bus.err_code);
      end
      ncomp++;
      if (bus.frame_data !== last_good) begin
         nfail++;
         $display("FAIL stop_hold got %h want %h",
                  bus.frame_data, last_good);
      end
   endtask

   task automatic test_timeout();
      logic [DW-1:0] d;
      d = 8'h96;
      sample(1'b0);
      for (int i = 0; i < 3; i++) sample(d[i]);
      push(1'b1, 2'b11, last_good, cyc + 16);
      idle(15);
      ncomp++;
      if (exp_q.size() != 1 || bus.busy !== 1'b1) begin
         nfail++;
         $display("FAIL to_early got q=%0d busy=%b want q=1 busy=1",
                  exp_q.size(), bus.busy);
      end
      idle(3);
      ncomp++;
      if (exp_q.size() != 0) begin
         nfail++;
         $display("FAIL to_missing got %0d left want 0", exp_q.size());
         exp_q.delete();
      end
      ncomp++;
      if (bus.busy !== 1'b0) begin
         nfail++;
         $display("FAIL to_busy got %b want 0", bus.busy);
      end
      send_frame(d, ~^d, 1'b1, 1, 2, 15);
      idle(2);
      ncomp++;
      if (exp_q.size() != 0) begin
         nfail++;
         $display("FAIL to_edge got %0d left want 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset_mid();
      sample(1'b0);
      for (int i = 0; i < 3; i++) sample(1'b1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      last_good = '0;
      ncomp++;
      if (bus.busy !== 1'b0 || bus.frame_data !== '0) begin
         nfail++;
         $display("FAIL rmid_state got busy=%b data=%h want 0 00",
                  bus.busy, bus.frame_data);
      end
      send_frame(8'hA5, 1'b1, 1'b1, 4, -1, 0);
      idle(2);
      ncomp++;
      if (exp_q.size() != 0) begin
         nfail++;
         $display("FAIL rmid_missing got %0d left want 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_back_to_back();
      send_frame(8'h01, 1'b0, 1'b1, 1, -1, 0);
      send_frame(8'hFF, 1'b1, 1'b1, 1, -1, 0);
      idle(2);
      ncomp++;
      if (exp_q.size() != 0) begin
         nfail++;
         $display("FAIL b2b_missing got %0d left want 0", exp_q.size());
         exp_q.delete();
      end
      ncomp++;
      if (bus.frame_data !== 8'hFF) begin
         nfail++;
         $display("FAIL b2b_data got %h want ff", bus.frame_data);
      end
   endtask

   initial begin
      bus.en = 1'b0;
      bus.data = 1'b1;
      test_reset();
      test_good();
`ifdef FRAME_PARITY_EN
      test_parity();
`endif
      test_stop();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      idle(4);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               ncomp, nfail);
      $finish;
   end
endmodule
